// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding and code-digit helper for lock_core_param
package lock_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'b000,
        ST_ENTRY    = 3'b001,
        ST_UNLOCKED = 3'b010,
        ST_ERROR    = 3'b011,
        ST_LOCKOUT  = 3'b100,
        ST_PROG     = 3'b101
    } lock_state_e;

    // Upper bounds for the flat code vector and a single digit handled by code_digit
    localparam int MAX_CODE_W  = 256;
    localparam int MAX_DIGIT_W = 32;

    // Digit 0 is the most significant field of the flat code and is entered first
    function automatic logic [MAX_DIGIT_W-1:0] code_digit(
        input logic [MAX_CODE_W-1:0] code,
        input int                    digit_w,
        input int                    code_len,
        input int                    idx
    );
        logic [MAX_CODE_W-1:0]  shifted;
        logic [MAX_DIGIT_W-1:0] mask;
        shifted = code >> ((code_len - 1 - idx) * digit_w);
        mask    = (MAX_DIGIT_W'(1) << digit_w) - MAX_DIGIT_W'(1);
        return shifted[MAX_DIGIT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/lock_btn_edge.sv
// rtl/lock_btn_edge.sv - button history register and single-cycle rising-edge pulse
module lock_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic hist_q;
    logic hist_d;

    // History resets high so a button held through reset never fires
    always_comb begin
        hist_d = btn;
    end

    // History register
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign pulse = btn & ~hist_q;

endmodule

// File: rtl/lock_core_param.sv
// rtl/lock_core_param.sv - parametrised combination-lock core with programmable code
module lock_core_param
    import lock_pkg::*;
#(
    parameter int                             DIGIT_W        = 4,
    parameter int                             CODE_LEN       = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]    DEFAULT_CODE   = 16'h1234,
    parameter int                             MAX_TRIES      = 3,
    parameter int                             ERROR_CYCLES   = 1000,
    parameter int                             LOCKOUT_CYCLES = 10000,
    parameter int                             TIMEOUT_CYCLES = 5000,
    parameter int                             RELOCK_CYCLES  = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DIGIT_W-1:0]                in_digit,
    input  logic                              enter_btn,
    input  logic                              lock_btn,
    input  logic                              prog_btn,
    output logic                              locked_led,
    output logic                              unlocked_led,
    output logic                              error_led,
    output logic                              lockout_led,
    output logic [2:0]                        state_leds,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0]    tries_left
);

    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);
    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int TMAX_A = (ERROR_CYCLES > LOCKOUT_CYCLES) ? ERROR_CYCLES : LOCKOUT_CYCLES;
    localparam int TMAX_B = (TIMEOUT_CYCLES > RELOCK_CYCLES) ? TIMEOUT_CYCLES : RELOCK_CYCLES;
    localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TMR_W  = $clog2(TMAX + 1);

    // Loads are N-1 because the state exits on the cycle the counter reads 0,
    // giving a dwell of exactly N cycles
    localparam logic [TMR_W-1:0] ERR_LOAD = TMR_W'((ERROR_CYCLES   > 0) ? ERROR_CYCLES   - 1 : 0);
    localparam logic [TMR_W-1:0] LKO_LOAD = TMR_W'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0);
    localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TMR_W-1:0] RLK_LOAD = TMR_W'((RELOCK_CYCLES  > 0) ? RELOCK_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CODE_LEN - 1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);

    lock_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic               mis_q, mis_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  stage_q, stage_d;

    logic               enter_e, lock_e, prog_e;
    logic [DIGIT_W-1:0] exp_digit;
    logic               dig_ne, mis_n, expired, last;

    lock_btn_edge u_enter_edge (.clk(clk), .reset(reset), .btn(enter_btn), .pulse(enter_e));
    lock_btn_edge u_lock_edge  (.clk(clk), .reset(reset), .btn(lock_btn),  .pulse(lock_e));
    lock_btn_edge u_prog_edge  (.clk(clk), .reset(reset), .btn(prog_btn),  .pulse(prog_e));

    // Next-state logic: sequence tracking, shared timer, code programming
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tries_d   = tries_q;
        mis_d     = mis_q;
        code_d    = code_q;
        stage_d   = stage_q;
        timer_d   = (timer_q != '0) ? timer_q - TMR_W'(1) : '0;
        exp_digit = DIGIT_W'(code_digit(MAX_CODE_W'(code_q), DIGIT_W, CODE_LEN, int'(cnt_q)));
        dig_ne    = (in_digit != exp_digit);
        mis_n     = mis_q | dig_ne;
        expired   = (timer_q == '0);
        last      = (cnt_q == LAST_IDX);

        case (state_q)
            ST_LOCKED: begin
                if (enter_e) begin
                    mis_d   = dig_ne;
                    cnt_d   = CNT_W'(1);
                    timer_d = TMO_LOAD;
                    state_d = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (enter_e) begin
                    mis_d   = mis_n;
                    cnt_d   = cnt_q + CNT_W'(1);
                    timer_d = TMO_LOAD;
                    if (last) begin
                        cnt_d = '0;
                        if (!mis_n) begin
                            tries_d = TRY_MAX;
                            timer_d = RLK_LOAD;
                            state_d = ST_UNLOCKED;
                        end else if (tries_q > TRY_W'(1)) begin
                            tries_d = tries_q - TRY_W'(1);
                            timer_d = ERR_LOAD;
                            state_d = ST_ERROR;
                        end else begin
                            tries_d = '0;
                            timer_d = LKO_LOAD;
                            state_d = ST_LOCKOUT;
                        end
                    end
                end else if (expired) begin
                    cnt_d   = '0;
                    state_d = ST_LOCKED;
                end
            end
            ST_ERROR: begin
                if (expired) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (expired) begin
                    tries_d = TRY_MAX;
                    state_d = ST_LOCKED;
                end
            end
            ST_UNLOCKED: begin
                if (lock_e) begin
                    state_d = ST_LOCKED;
                end else if (prog_e) begin
                    cnt_d   = '0;
                    timer_d = TMO_LOAD;
                    state_d = ST_PROG;
                end else if (enter_e) begin
                    timer_d = RLK_LOAD;
                end else if ((RELOCK_CYCLES > 0) && expired) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_PROG: begin
                if (lock_e) begin
                    cnt_d   = '0;
                    state_d = ST_LOCKED;
                end else if (enter_e) begin
                    stage_d[(CODE_LEN - 1 - int'(cnt_q)) * DIGIT_W +: DIGIT_W] = in_digit;
                    cnt_d   = cnt_q + CNT_W'(1);
                    timer_d = TMO_LOAD;
                    if (last) begin
                        code_d  = stage_d;
                        cnt_d   = '0;
                        timer_d = RLK_LOAD;
                        state_d = ST_UNLOCKED;
                    end
                end else if (expired) begin
                    cnt_d   = '0;
                    timer_d = RLK_LOAD;
                    state_d = ST_UNLOCKED;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_LOCKED;
            end
        endcase
    end

    // State, counters, timer and code registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOCKED;
            cnt_q   <= '0;
            tries_q <= TRY_MAX;
            mis_q   <= 1'b0;
            timer_q <= '0;
            code_q  <= DEFAULT_CODE;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
            mis_q   <= mis_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            stage_q <= stage_d;
        end
    end

    assign locked_led   = (state_q == ST_LOCKED)   || (state_q == ST_ENTRY);
    assign unlocked_led = (state_q == ST_UNLOCKED) || (state_q == ST_PROG);
    assign error_led    = (state_q == ST_ERROR)    || (state_q == ST_LOCKOUT);
    assign lockout_led  = (state_q == ST_LOCKOUT);
    assign state_leds   = state_q;
    assign digit_count  = cnt_q;
    assign tries_left   = tries_q;

endmodule

// File: tb/tb_lock_core_param.sv
// tb/tb_lock_core_param.sv - directed self-checking bench for lock_core_param
module tb_lock_core_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_digit;
    logic       enter_btn, lock_btn, prog_btn;
    logic       locked_led, unlocked_led, error_led, lockout_led;
    logic [2:0] state_leds;
    logic [2:0] digit_count;
    logic [1:0] tries_left;

    int n_vec = 0;
    int n_err = 0;
    int n_cyc;

    lock_core_param #(
        .ERROR_CYCLES   (4),
        .LOCKOUT_CYCLES (16),
        .TIMEOUT_CYCLES (32),
        .RELOCK_CYCLES  (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_digit     (in_digit),
        .enter_btn    (enter_btn),
        .lock_btn     (lock_btn),
        .prog_btn     (prog_btn),
        .locked_led   (locked_led),
        .unlocked_led (unlocked_led),
        .error_led    (error_led),
        .lockout_led  (lockout_led),
        .state_leds   (state_leds),
        .digit_count  (digit_count),
        .tries_left   (tries_left)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        in_digit  = d;
        enter_btn = 1'b1;
        tick();
        enter_btn = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            press(c[15-4*i -: 4]);
        end
    endtask

    task automatic pulse_lock();
        lock_btn = 1'b1;
        tick();
        lock_btn = 1'b0;
    endtask

    task automatic pulse_prog();
        prog_btn = 1'b1;
        tick();
        prog_btn = 1'b0;
    endtask

    task automatic count_high(input bit use_lockout, output int n);
        n = 0;
        while (n < 200 && (use_lockout ? lockout_led : error_led)) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_digit = '0;
        enter_btn = 1'b0; lock_btn = 1'b0; prog_btn = 1'b0;
        repeat (3) tick();
        check("rst_locked_led",   locked_led,   1);
        check("rst_unlocked_led", unlocked_led, 0);
        check("rst_error_led",    error_led,    0);
        check("rst_lockout_led",  lockout_led,  0);
        check("rst_state",        state_leds,   0);
        check("rst_count",        digit_count,  0);
        check("rst_tries",        tries_left,   3);
        reset = 1'b0;
        tick();

        // 1: correct default code
        enter_code(16'h1234);
        check("t1_state",    state_leds,   3'b010);
        check("t1_unlocked", unlocked_led, 1);
        check("t1_tries",    tries_left,   3);
        lock_btn = 1'b1; prog_btn = 1'b1;
        tick();
        lock_btn = 1'b0; prog_btn = 1'b0;
        check("t1_lock_prio", state_leds, 3'b000);

        // 2: three wrong codes
        tick(); enter_code(16'h1235);
        check("t2_err1_state", state_leds, 3'b011);
        check("t2_err1_tries", tries_left, 2);
        count_high(1'b0, n_cyc);
        check("t2_err1_cycles", n_cyc, 4);
        tick(); enter_code(16'h1235);
        check("t2_err2_tries", tries_left, 1);
        count_high(1'b0, n_cyc);
        check("t2_err2_cycles", n_cyc, 4);
        tick(); enter_code(16'h1235);
        check("t2_lko_state", state_leds, 3'b100);
        check("t2_lko_tries", tries_left, 0);
        check("t2_lko_err",   error_led,  1);
        count_high(1'b1, n_cyc);
        check("t2_lko_cycles", n_cyc, 16);
        check("t2_after_state", state_leds, 3'b000);
        check("t2_after_tries", tries_left, 3);

        // 3: program 9876
        tick(); enter_code(16'h1234);
        check("t3_unlock", state_leds, 3'b010);
        tick(); pulse_prog();
        check("t3_prog_state", state_leds, 3'b101);
        check("t3_prog_count", digit_count, 0);
        tick(); enter_code(16'h9876);
        check("t3_prog_done", state_leds, 3'b010);
        tick(); pulse_lock();
        check("t3_locked", state_leds, 3'b000);
        tick(); enter_code(16'h1234);
        check("t3_old_fails", state_leds, 3'b011);
        check("t3_old_tries", tries_left, 2);
        count_high(1'b0, n_cyc);
        tick(); enter_code(16'h9876);
        check("t3_new_unlocks", state_leds, 3'b010);
        check("t3_new_tries",   tries_left, 3);

        // 4: PROG abort and PROG timeout
        reset = 1'b1; tick(); reset = 1'b0; tick();
        enter_code(16'h1234);
        tick(); pulse_prog();
        tick(); press(4'h5);
        tick(); press(4'h6);
        check("t4_partial_count", digit_count, 2);
        tick(); pulse_lock();
        check("t4_abort_state", state_leds, 3'b000);
        check("t4_abort_count", digit_count, 0);
        tick(); enter_code(16'h1234);
        check("t4_code_kept", state_leds, 3'b010);
        tick(); pulse_prog();
        repeat (31) tick();
        check("t4_prog_dwell", state_leds, 3'b101);
        tick();
        check("t4_prog_timeout", state_leds, 3'b010);
        tick(); pulse_lock();

        // 5: entry timeout and held button
        tick(); press(4'h1);
        tick(); press(4'h2);
        check("t5_entry_count", digit_count, 2);
        check("t5_entry_state", state_leds,  3'b001);
        repeat (31) tick();
        check("t5_entry_dwell", state_leds, 3'b001);
        tick();
        check("t5_timeout_state", state_leds,  3'b000);
        check("t5_timeout_tries", tries_left,  3);
        check("t5_timeout_count", digit_count, 0);
        in_digit = 4'h1; enter_btn = 1'b1;
        repeat (10) tick();
        enter_btn = 1'b0;
        check("t5_hold_count", digit_count, 1);
        repeat (25) tick();
        check("t5_hold_timeout", state_leds, 3'b000);

        // 6: auto-relock, reset mid-entry restores default code
        tick(); enter_code(16'h1234);
        repeat (63) tick();
        check("t6_relock_dwell", state_leds, 3'b010);
        tick();
        check("t6_relocked", state_leds, 3'b000);
        tick(); enter_code(16'h1234);
        tick(); pulse_prog();
        tick(); enter_code(16'h9876);
        tick(); pulse_lock();
        tick(); press(4'h9);
        check("t6_mid_entry", state_leds, 3'b001);
        reset = 1'b1; tick();
        check("t6_rst_state",  state_leds,  3'b000);
        check("t6_rst_count",  digit_count, 0);
        check("t6_rst_tries",  tries_left,  3);
        check("t6_rst_locked", locked_led,  1);
        reset = 1'b0; tick();
        enter_code(16'h9876);
        check("t6_prog_lost", state_leds, 3'b011);
        count_high(1'b0, n_cyc);
        tick(); enter_code(16'h1234);
        check("t6_default_back", state_leds, 3'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
